telemetry_framer: RTL and testbench
===================================

TELEMETRY_FRAMER -- requirements
Module: telemetry_framer

Interface
REQ-001 Parameter PAYLOAD_LEN, default 16: payload bytes per frame; legal range 1..255.
REQ-002 Parameter SYNC0, default 8'hEB: first sync byte.
REQ-003 Parameter SYNC1, default 8'h90: second sync byte.
REQ-004 clk  in  1  system clock; the only clock.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 tx_enable  in  1  transmit window grant from orbit control; high = window open.
REQ-007 data_in  in  8  payload byte from the telemetry source.
REQ-008 data_valid  in  1  data_in is valid.
REQ-009 data_ready  out  1  framer accepts data_in this cycle.
REQ-010 uart_data  out  8  byte to the UART transmitter.
REQ-011 uart_valid  out  1  uart_data is valid.
REQ-012 uart_ready  in  1  UART accepts uart_data this cycle.
REQ-013 busy  out  1  high in any state other than IDLE.
REQ-014 frame_count  out  16  number of completed frames since reset.

Function
REQ-015 Frame byte order SHALL be: SYNC0, SYNC1, SEQ, PAYLOAD_LEN payload bytes, CHK.
REQ-016 FSM states SHALL be IDLE, SYNC0, SYNC1, SEQ, PAYLOAD and CHK.
REQ-017 A byte transfers on the UART side only in a cycle with uart_valid=1 and uart_ready=1; the FSM advances only on a transfer.
REQ-018 IDLE->SYNC0 SHALL occur on a cycle with tx_enable=1 and data_valid=1; no frame starts while tx_enable=0.
REQ-019 In SYNC0/SYNC1/SEQ/CHK, uart_valid=1 and uart_data=SYNC0/SYNC1/seq/chk respectively; data_ready=0.
REQ-020 In PAYLOAD: uart_data=data_in, uart_valid=data_valid and data_ready=uart_ready (pass-through, zero latency).
REQ-021 A source underrun (data_valid=0) in PAYLOAD SHALL stall the frame with uart_valid=0; no filler byte is inserted.
REQ-022 An 8-bit payload counter SHALL count transfers; PAYLOAD->CHK on the transfer where count = PAYLOAD_LEN-1.
REQ-023 chk SHALL be the 8-bit modulo-256 sum of seq and all payload bytes of the frame; sync bytes are excluded.
REQ-024 On the CHK transfer: state->IDLE, seq increments (255 wraps to 0), and frame_count increments (saturates at 16'hFFFF).
REQ-025 A tx_enable fall mid-frame SHALL NOT abort the frame; the frame completes and no new frame starts.
REQ-026 A frame may start in the cycle after the CHK transfer if the REQ-018 condition holds (back-to-back frames).
REQ-027 uart_data and uart_valid SHALL hold stable while uart_valid=1 and uart_ready=0 (SYNC0, SYNC1, SEQ and CHK states; in PAYLOAD this relies on the source holding its data).
REQ-028 busy SHALL be 0 only in IDLE.

Reset
REQ-029 On reset=1 at a clk edge: state=IDLE, seq=0, chk=0, payload count=0, frame_count=0.
REQ-030 During and after reset until a frame starts: uart_valid=0, data_ready=0, busy=0, uart_data=8'h00.
REQ-031 Reset mid-frame SHALL abandon the partial frame immediately; no CHK byte is emitted.

Structure
REQ-032 State encoding and the default SYNC0/SYNC1 constants SHALL live in a shared package (telemetry_pkg) for reuse by the ground-side deframer.
REQ-033 The design SHALL be a single module with no sub-modules; the checksum accumulator is inline.

Verification
REQ-034 PAYLOAD_LEN=4, tx_enable=1, uart_ready=1, source bytes 01,02,03,04 -> UART sequence EB,90,00,01,02,03,04,0A; frame_count=1.
REQ-035 tx_enable drops after the second payload byte -> frame still ends with a correct CHK; busy falls, and no further SYNC0 appears while tx_enable=0.
REQ-036 uart_ready toggles 1,0,1,0 across each byte -> every byte is emitted exactly once, held stable while stalled, and the checksum is correct.
REQ-037 Run 257 frames continuously -> seq values 00..FF then 00, and frame_count=257.
REQ-038 Assert reset in the PAYLOAD state -> the next cycle shows uart_valid=0 and busy=0; the next frame starts with seq=00.
REQ-039 data_valid is held low for 5 cycles mid-payload -> uart_valid=0 for those cycles, no bytes are lost, and the CHK value is unchanged.

Source files
------------

// File: rtl/telemetry_pkg.sv
// telemetry_pkg
// Shared definitions for the telemetry downlink framer and the ground-side
// deframer: FSM state encoding and the default frame sync word.
package telemetry_pkg;

  // Frame FSM states. The byte order on the wire follows the state order:
  // sync0, sync1, sequence number, payload bytes, checksum.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SYNC0   = 3'd1,
    ST_SYNC1   = 3'd2,
    ST_SEQ     = 3'd3,
    ST_PAYLOAD = 3'd4,
    ST_CHK     = 3'd5
  } frame_state_e;

  // Default two-byte sync word that opens every frame.
  localparam logic [7:0] DEFAULT_SYNC0 = 8'hEB;
  localparam logic [7:0] DEFAULT_SYNC1 = 8'h90;

endpackage : telemetry_pkg

// File: rtl/telemetry_framer.sv
// telemetry_framer
// Wraps a byte stream from a telemetry source into fixed-length frames
// (SYNC0, SYNC1, SEQ, PAYLOAD_LEN payload bytes, CHK) and hands them to a
// UART transmitter over a valid/ready byte interface. Frames start only
// while the orbit-control transmit window (tx_enable) is open and data is
// waiting; once started, a frame always runs to completion.
//
// Ports:
//   clk         system clock (only clock)
//   reset       synchronous active-high reset
//   tx_enable   transmit window open
//   data_in     payload byte from the source
//   data_valid  data_in valid
//   data_ready  framer accepts data_in this cycle
//   uart_data   byte to the UART
//   uart_valid  uart_data valid
//   uart_ready  UART accepts uart_data this cycle
//   busy        framer is not idle
//   frame_count completed frames since reset (saturating)
module telemetry_framer
  import telemetry_pkg::*;
#(
  parameter int         PAYLOAD_LEN = 16,
  parameter logic [7:0] SYNC0       = DEFAULT_SYNC0,
  parameter logic [7:0] SYNC1       = DEFAULT_SYNC1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tx_enable,
  input  logic [7:0]  data_in,
  input  logic        data_valid,
  output logic        data_ready,
  output logic [7:0]  uart_data,
  output logic        uart_valid,
  input  logic        uart_ready,
  output logic        busy,
  output logic [15:0] frame_count
);

  // Index of the last payload byte; the transfer of this byte ends PAYLOAD.
  localparam logic [7:0] LAST_IDX = 8'(PAYLOAD_LEN - 1);

  frame_state_e state_q, state_d;
  logic [7:0]   seq_q, seq_d;
  logic [7:0]   chk_q, chk_d;
  logic [7:0]   cnt_q, cnt_d;
  logic [15:0]  fc_q, fc_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      seq_q   <= 8'h00;
      chk_q   <= 8'h00;
      cnt_q   <= 8'h00;
      fc_q    <= 16'h0000;
    end else begin
      state_q <= state_d;
      seq_q   <= seq_d;
      chk_q   <= chk_d;
      cnt_q   <= cnt_d;
      fc_q    <= fc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    seq_d      = seq_q;
    chk_d      = chk_q;
    cnt_d      = cnt_q;
    fc_d       = fc_q;
    uart_valid = 1'b0;
    uart_data  = 8'h00;
    data_ready = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Only start when a payload byte is already waiting, so a frame is
        // never opened on an empty source.
        if (tx_enable && data_valid) begin
          state_d = ST_SYNC0;
        end
      end

      ST_SYNC0: begin
        uart_valid = 1'b1;
        uart_data  = SYNC0;
        if (uart_ready) state_d = ST_SYNC1;
      end

      ST_SYNC1: begin
        uart_valid = 1'b1;
        uart_data  = SYNC1;
        if (uart_ready) state_d = ST_SEQ;
      end

      ST_SEQ: begin
        uart_valid = 1'b1;
        uart_data  = seq_q;
        if (uart_ready) begin
          // The checksum covers seq, so it seeds the accumulator.
          chk_d   = seq_q;
          cnt_d   = 8'h00;
          state_d = ST_PAYLOAD;
        end
      end

      ST_PAYLOAD: begin
        // Zero-latency pass-through: the source sees the UART's ready
        // directly, and an underrun simply stalls the frame.
        uart_valid = data_valid;
        uart_data  = data_in;
        data_ready = uart_ready;
        if (data_valid && uart_ready) begin
          chk_d = chk_q + data_in;
          if (cnt_q == LAST_IDX) begin
            cnt_d   = 8'h00;
            state_d = ST_CHK;
          end else begin
            cnt_d = cnt_q + 8'h01;
          end
        end
      end

      ST_CHK: begin
        uart_valid = 1'b1;
        uart_data  = chk_q;
        if (uart_ready) begin
          state_d = ST_IDLE;
          seq_d   = seq_q + 8'h01;
          fc_d    = (fc_q == 16'hFFFF) ? fc_q : fc_q + 16'h0001;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy        = (state_q != ST_IDLE);
  assign frame_count = fc_q;

endmodule : telemetry_framer

// File: tb/tb_telemetry_framer.sv
// tb_telemetry_framer
// Scoreboard bench for telemetry_framer with PAYLOAD_LEN=4. Stimulus pushes
// the expected UART byte stream into exp_q and the payload into src_q; a
// driver process plays the source and UART-ready side, and a monitor process
// pops exp_q on every UART transfer and compares.
module tb_telemetry_framer;

  localparam int PLEN = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tx_enable = 1'b0;
  logic [7:0]  data_in = 8'h00;
  logic        data_valid = 1'b0;
  logic        data_ready;
  logic [7:0]  uart_data;
  logic        uart_valid;
  logic        uart_ready = 1'b1;
  logic        busy;
  logic [15:0] frame_count;

  always #5 clk = ~clk;

  telemetry_framer #(.PAYLOAD_LEN(PLEN)) dut (
    .clk         (clk),
    .reset       (reset),
    .tx_enable   (tx_enable),
    .data_in     (data_in),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
    .uart_data   (uart_data),
    .uart_valid  (uart_valid),
    .uart_ready  (uart_ready),
    .busy        (busy),
    .frame_count (frame_count)
  );

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0] exp_q[$];
  logic [7:0] src_q[$];

  int   pop_cnt = 0;
  int   gap_at = -1;
  int   gap_left = 0;
  logic gap_active = 1'b0;
  int   gap_obs = 0;
  int   ready_mode = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    tests_run++;
    tests_failed++;
    $display("FAIL %s: bound expired", name);
  endtask

  // Expected wire bytes for one frame; payload also goes to the source.
  task automatic queue_frame(input logic [7:0] s, input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] b3, input logic [7:0] chk);
    exp_q.push_back(8'hEB);
    exp_q.push_back(8'h90);
    exp_q.push_back(s);
    exp_q.push_back(b0);
    exp_q.push_back(b1);
    exp_q.push_back(b2);
    exp_q.push_back(b3);
    exp_q.push_back(chk);
    src_q.push_back(b0);
    src_q.push_back(b1);
    src_q.push_back(b2);
    src_q.push_back(b3);
  endtask

  task automatic wait_idle(input string name, input int bound);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (n >= bound) fail_now(name);
  endtask

  task automatic wait_pops(input string name, input int target, input int bound);
    int n;
    n = 0;
    while (pop_cnt < target && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (n >= bound) fail_now(name);
  endtask

  // Source and UART-ready driver. Handshakes are sampled at the negedge and
  // acted on just after the following posedge.
  initial begin : driver
    logic fire;
    fire = 1'b0;
    forever begin
      @(negedge clk);
      fire = data_valid && data_ready && !reset;
      @(posedge clk);
      #1;
      if (fire && src_q.size() > 0) begin
        void'(src_q.pop_front());
        pop_cnt++;
        if (pop_cnt == gap_at) gap_left = 5;
      end
      uart_ready = (ready_mode == 0) ? 1'b1 : ~uart_ready;
      if (gap_left > 0) begin
        gap_active = 1'b1;
        gap_left--;
        data_valid = 1'b0;
      end else begin
        gap_active = 1'b0;
        if (src_q.size() > 0) begin
          data_valid = 1'b1;
          data_in    = src_q[0];
        end else begin
          data_valid = 1'b0;
        end
      end
    end
  end

  // Monitor: compares every UART transfer against the scoreboard and checks
  // that a stalled byte is held unchanged.
  initial begin : monitor
    logic       hold_v;
    logic [7:0] hold_d;
    logic [7:0] e;
    hold_v = 1'b0;
    hold_d = 8'h00;
    forever begin
      @(negedge clk);
      if (reset) begin
        hold_v = 1'b0;
      end else begin
        if (hold_v) check("stall_hold", {23'b0, uart_valid, uart_data}, {23'b0, 1'b1, hold_d});
        if (gap_active && busy) begin
          gap_obs++;
          check("underrun_valid", {31'b0, uart_valid}, 32'd0);
        end
        if (uart_valid && uart_ready) begin
          if (exp_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL unexpected_byte: got %02h expected no transfer", uart_data);
          end else begin
            e = exp_q.pop_front();
            check("uart_byte", {24'b0, uart_data}, {24'b0, e});
          end
        end
        hold_v = uart_valid && !uart_ready;
        hold_d = uart_data;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int base;
    int busy_seen;
    logic [7:0] s;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_uart_valid", {31'b0, uart_valid}, 32'd0);
    check("rst_data_ready", {31'b0, data_ready}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_uart_data", {24'b0, uart_data}, 32'h00);
    check("rst_frame_count", {16'b0, frame_count}, 32'd0);
    @(posedge clk); #2;
    reset = 1'b0;

    // Basic frame: EB 90 00 01 02 03 04 0A
    tx_enable = 1'b1;
    queue_frame(8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A);
    wait_idle("t1_idle", 200);
    @(negedge clk);
    check("t1_frame_count", {16'b0, frame_count}, 32'd1);

    // Window closes after the second payload byte; extra source data waits.
    base = pop_cnt;
    queue_frame(8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h0F);
    for (int i = 0; i < 4; i++) src_q.push_back(8'h55);
    wait_pops("t2_pops", base + 2, 200);
    @(posedge clk); #2;
    tx_enable = 1'b0;
    wait_idle("t2_idle", 200);
    busy_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy) busy_seen++;
    end
    check("t2_no_restart", busy_seen, 32'd0);
    check("t2_frame_count", {16'b0, frame_count}, 32'd2);
    @(posedge clk); #2;
    src_q.delete();
    repeat (2) @(posedge clk);
    #2;
    tx_enable = 1'b1;

    // UART ready toggling every cycle
    ready_mode = 1;
    queue_frame(8'h02, 8'h10, 8'h20, 8'h30, 8'h40, 8'hA2);
    wait_idle("t3_idle", 400);
    ready_mode = 0;
    @(negedge clk);
    check("t3_frame_count", {16'b0, frame_count}, 32'd3);

    // Five-cycle source underrun after the second payload byte
    base = pop_cnt;
    gap_at = base + 2;
    gap_obs = 0;
    queue_frame(8'h03, 8'hFF, 8'h01, 8'h80, 8'h7F, 8'h02);
    wait_idle("t4_idle", 200);
    gap_at = -1;
    check("t4_gap_cycles", gap_obs, 32'd5);
    @(negedge clk);
    check("t4_frame_count", {16'b0, frame_count}, 32'd4);

    // Reset in the middle of the payload
    base = pop_cnt;
    queue_frame(8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h1E);
    wait_pops("t5_pops", base + 2, 200);
    @(posedge clk); #2;
    reset = 1'b1;
    tx_enable = 1'b0;
    @(posedge clk); #2;
    reset = 1'b0;
    exp_q.delete();
    src_q.delete();
    @(negedge clk);
    check("t5_uart_valid", {31'b0, uart_valid}, 32'd0);
    check("t5_busy", {31'b0, busy}, 32'd0);
    check("t5_frame_count", {16'b0, frame_count}, 32'd0);
    repeat (2) @(posedge clk);
    #2;
    tx_enable = 1'b1;
    queue_frame(8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA);
    wait_idle("t5_idle", 200);
    @(negedge clk);
    check("t5_after_frame_count", {16'b0, frame_count}, 32'd1);

    // 257 back-to-back frames from a clean reset: seq 00..FF then 00
    @(posedge clk); #2;
    reset = 1'b1;
    @(posedge clk); #2;
    reset = 1'b0;
    for (int i = 0; i < 257; i++) begin
      s = 8'(i);
      queue_frame(s, s, 8'h01, 8'h02, 8'h03, 8'(s + s + 8'h06));
    end
    wait_idle("t6_idle", 5000);
    @(negedge clk);
    check("t6_frame_count", {16'b0, frame_count}, 32'd257);
    check("t6_busy", {31'b0, busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_telemetry_framer
